random_source: RTL and testbench

//  Pseudo-random number source for the mole scheduler. Free-running Galois LFSR

---
 rtl/random_source.sv | 145 ++++++++++++++
 tb/tb_random_source.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/random_source.sv
// ---------------------------------------------------------------------------
// random_source
// Pseudo-random number source for the mole scheduler. A free-running Galois
// LFSR is sampled through a req/ack handshake. Each accepted request yields
// one WIDTH-bit sample, zero-extended to 128 bits. The sample feeds
// tuner.number and the constant rnd_power feeds tuner.power.
//
// Ports
//   clk         in   1      system clock, rising edge
//   reset       in   1      asynchronous active-high reset
//   seed_load   in   1      load seed into the LFSR this cycle
//   seed        in   WIDTH  seed value; 0 is replaced by DEFAULT_SEED
//   req         in   1      request a new sample (sampled in IDLE only)
//   ack         in   1      consumer took rnd_number (used in HOLD only)
//   stir        in   1      (RNG_STIR_EN only) xor stir_data into the step
//   stir_data   in   WIDTH  (RNG_STIR_EN only) entropy mixed into the LFSR
//   rnd_valid   out  1      rnd_number holds a fresh sample
//   rnd_number  out  128    sample, zero-extended from WIDTH bits
//   rnd_power   out  7      constant WIDTH, drives tuner.power
//   busy        out  1      high while in STEP
//
// Configuration macro: RNG_STIR_EN adds the stir/stir_data ports.
// ---------------------------------------------------------------------------
module random_source #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] TAPS         = 32'h80200003,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 32'h00000001,
  parameter int               STEPS        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  input  logic             ack,
`ifdef RNG_STIR_EN
  input  logic             stir,
  input  logic [WIDTH-1:0] stir_data,
`endif
  output logic             rnd_valid,
  output logic [127:0]     rnd_number,
  output logic [6:0]       rnd_power,
  output logic             busy
);

  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_STEP = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] nxt_raw;
  logic [WIDTH-1:0] step_val;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rnd_valid_q, rnd_valid_d;
  logic [127:0]     rnd_number_q, rnd_number_d;
  logic             busy_q, busy_d;

  // Next LFSR value: Galois step, optional stir mix, zero guard, then the
  // seed load which overrides everything else.
  always_comb begin
    nxt_raw  = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    step_val = nxt_raw;
`ifdef RNG_STIR_EN
    if (stir) begin
      step_val = nxt_raw ^ stir_data;
    end
`endif
    // An all-zero LFSR would lock up forever.
    if (step_val == '0) begin
      step_val = DEFAULT_SEED;
    end
    if (seed_load) begin
      lfsr_d = (seed == '0) ? DEFAULT_SEED : seed;
    end else begin
      lfsr_d = step_val;
    end
  end

  // Request handshake FSM. The captured sample is the value being written
  // into the LFSR on the capture edge, not the value currently held.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rnd_valid_d  = rnd_valid_q;
    rnd_number_d = rnd_number_q;
    busy_d       = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_STEP;
          cnt_d   = CNT_W'(STEPS - 1);
          busy_d  = 1'b1;
        end
      end
      ST_STEP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rnd_number_d = {{(128-WIDTH){1'b0}}, lfsr_d};
          rnd_valid_d  = 1'b1;
          busy_d       = 1'b0;
          state_d      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (ack) begin
          rnd_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rnd_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q       <= DEFAULT_SEED;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rnd_valid_q  <= 1'b0;
      rnd_number_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      lfsr_q       <= lfsr_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rnd_valid_q  <= rnd_valid_d;
      rnd_number_q <= rnd_number_d;
      busy_q       <= busy_d;
    end
  end

  assign rnd_valid  = rnd_valid_q;
  assign rnd_number = rnd_number_q;
  assign busy       = busy_q;
  assign rnd_power  = 7'(WIDTH);

endmodule

// File: tb/tb_random_source.sv
// ---------------------------------------------------------------------------
// tb_random_source
// Directed bench for random_source. Two instances share clock and reset:
// dut4 uses the default STEPS=4, dut1 uses STEPS=1. Expected LFSR values are
// hand-computed from seed 1 with taps 32'h80200003:
//   1 -> 80200003 -> C0300002 -> 60180001 -> B02C0003
// ---------------------------------------------------------------------------
module tb_random_source;

  logic clk = 1'b0;
  logic reset;

  logic         seed_load4, req4, ack4;
  logic [31:0]  seed4;
  logic         rnd_valid4, busy4;
  logic [127:0] rnd_number4;
  logic [6:0]   rnd_power4;

  logic         seed_load1, req1, ack1;
  logic [31:0]  seed1;
  logic         rnd_valid1, busy1;
  logic [127:0] rnd_number1;
  logic [6:0]   rnd_power1;

`ifdef RNG_STIR_EN
  logic         stir4, stir1;
  logic [31:0]  stir_data4, stir_data1;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  random_source dut4 (
    .clk(clk), .reset(reset), .seed_load(seed_load4), .seed(seed4),
    .req(req4), .ack(ack4),
`ifdef RNG_STIR_EN
    .stir(stir4), .stir_data(stir_data4),
`endif
    .rnd_valid(rnd_valid4), .rnd_number(rnd_number4),
    .rnd_power(rnd_power4), .busy(busy4)
  );

  random_source #(.STEPS(1)) dut1 (
    .clk(clk), .reset(reset), .seed_load(seed_load1), .seed(seed1),
    .req(req1), .ack(ack1),
`ifdef RNG_STIR_EN
    .stir(stir1), .stir_data(stir_data1),
`endif
    .rnd_valid(rnd_valid1), .rnd_number(rnd_number1),
    .rnd_power(rnd_power1), .busy(busy1)
  );

  // Advance one clock and sample shortly after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    checks++; if (rnd_valid4 !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%0b exp=0", rnd_valid4); end
    checks++; if (rnd_number4 !== 128'h0) begin failures++; $display("[TB] FAIL reset_number got=%h exp=0", rnd_number4); end
    checks++; if (busy4 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy4); end
    checks++; if (dut4.lfsr_q !== 32'h00000001) begin failures++; $display("[TB] FAIL reset_lfsr got=%h exp=00000001", dut4.lfsr_q); end
    checks++; if (rnd_power4 !== 7'd32) begin failures++; $display("[TB] FAIL rnd_power got=%0d exp=32", rnd_power4); end
    reset = 1'b0;
    // Bring dut4 into HOLD, then reset asynchronously mid-cycle.
    seed_load4 = 1'b1; seed4 = 32'h12345678; req4 = 1'b1;
    tick();
    seed_load4 = 1'b0; req4 = 1'b0;
    repeat (4) tick();
    checks++; if (rnd_valid4 !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset_valid got=%0b exp=1", rnd_valid4); end
    #2 reset = 1'b1;
    #1;
    checks++; if (rnd_valid4 !== 1'b0) begin failures++; $display("[TB] FAIL async_valid got=%0b exp=0", rnd_valid4); end
    checks++; if (rnd_number4 !== 128'h0) begin failures++; $display("[TB] FAIL async_number got=%h exp=0", rnd_number4); end
    checks++; if (busy4 !== 1'b0) begin failures++; $display("[TB] FAIL async_busy got=%0b exp=0", busy4); end
    #1 reset = 1'b0;
    #1;
    checks++; if (dut4.lfsr_q !== 32'h00000001) begin failures++; $display("[TB] FAIL release_lfsr got=%h exp=00000001", dut4.lfsr_q); end
    tick();
    checks++; if (dut4.lfsr_q !== 32'h80200003) begin failures++; $display("[TB] FAIL free_run_lfsr got=%h exp=80200003", dut4.lfsr_q); end
    checks++; if (busy4 !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_idle got=%0b exp=0", busy4); end
  endtask

  task automatic test_steps1();
    seed_load1 = 1'b1; seed1 = 32'h1; req1 = 1'b1;
    tick();
    seed_load1 = 1'b0; req1 = 1'b0;
    checks++; if (dut1.lfsr_q !== 32'h00000001) begin failures++; $display("[TB] FAIL s1_seed got=%h exp=00000001", dut1.lfsr_q); end
    checks++; if (busy1 !== 1'b1) begin failures++; $display("[TB] FAIL s1_busy got=%0b exp=1", busy1); end
    checks++; if (rnd_valid1 !== 1'b0) begin failures++; $display("[TB] FAIL s1_early_valid got=%0b exp=0", rnd_valid1); end
    tick();
    checks++; if (rnd_valid1 !== 1'b1) begin failures++; $display("[TB] FAIL s1_valid got=%0b exp=1", rnd_valid1); end
    checks++; if (rnd_number1 !== 128'h80200003) begin failures++; $display("[TB] FAIL s1_number got=%h exp=80200003", rnd_number1); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("[TB] FAIL s1_busy_clear got=%0b exp=0", busy1); end
    tick();
    checks++; if (dut1.lfsr_q !== 32'hC0300002) begin failures++; $display("[TB] FAIL s1_lfsr2 got=%h exp=C0300002", dut1.lfsr_q); end
    tick();
    checks++; if (dut1.lfsr_q !== 32'h60180001) begin failures++; $display("[TB] FAIL s1_lfsr3 got=%h exp=60180001", dut1.lfsr_q); end
    checks++; if (rnd_number1 !== 128'h80200003) begin failures++; $display("[TB] FAIL s1_hold got=%h exp=80200003", rnd_number1); end
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    checks++; if (rnd_valid1 !== 1'b0) begin failures++; $display("[TB] FAIL s1_ack got=%0b exp=0", rnd_valid1); end
  endtask

  task automatic test_zero_seed();
    int zero_hits;
    zero_hits = 0;
    seed_load1 = 1'b1; seed1 = 32'h0;
    tick();
    seed_load1 = 1'b0;
    checks++; if (dut1.lfsr_q !== 32'h00000001) begin failures++; $display("[TB] FAIL zero_seed got=%h exp=00000001", dut1.lfsr_q); end
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (dut1.lfsr_q == 32'h0) zero_hits++;
    end
    checks++; if (zero_hits !== 0) begin failures++; $display("[TB] FAIL lfsr_never_zero got=%0d exp=0", zero_hits); end
  endtask

  task automatic test_steps4();
    seed_load4 = 1'b1; seed4 = 32'h1; req4 = 1'b1;
    tick();
    seed_load4 = 1'b0; req4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (busy4 !== 1'b1 || rnd_valid4 !== 1'b0) begin failures++; $display("[TB] FAIL s4_busy_%0d got=%0b/%0b exp=1/0", k, busy4, rnd_valid4); end
      tick();
    end
    checks++; if (rnd_valid4 !== 1'b1) begin failures++; $display("[TB] FAIL s4_valid got=%0b exp=1", rnd_valid4); end
    checks++; if (busy4 !== 1'b0) begin failures++; $display("[TB] FAIL s4_busy_clear got=%0b exp=0", busy4); end
    checks++; if (rnd_number4 !== 128'hB02C0003) begin failures++; $display("[TB] FAIL s4_number got=%h exp=B02C0003", rnd_number4); end
    for (int k = 0; k < 20; k++) begin
      req4 = k[0];
      tick();
      checks++; if (rnd_number4 !== 128'hB02C0003 || rnd_valid4 !== 1'b1 || busy4 !== 1'b0) begin
        failures++; $display("[TB] FAIL s4_hold_%0d got=%h/%0b/%0b exp=B02C0003/1/0", k, rnd_number4, rnd_valid4, busy4);
      end
    end
    req4 = 1'b0; ack4 = 1'b1;
    tick();
    ack4 = 1'b0;
    checks++; if (rnd_valid4 !== 1'b0) begin failures++; $display("[TB] FAIL s4_ack got=%0b exp=0", rnd_valid4); end
    tick();
    checks++; if (busy4 !== 1'b0) begin failures++; $display("[TB] FAIL s4_idle got=%0b exp=0", busy4); end
  endtask

  task automatic test_handshake();
    int budget;
    req4 = 1'b1;
    tick();
    req4 = 1'b0;
    budget = 0;
    while (rnd_valid4 !== 1'b1 && budget < 50) begin
      tick();
      budget++;
    end
    checks++; if (rnd_valid4 !== 1'b1) begin failures++; $display("[TB] FAIL hs_wait_valid got=%0b exp=1", rnd_valid4); end
    req4 = 1'b1; ack4 = 1'b1;
    tick();
    req4 = 1'b0; ack4 = 1'b0;
    checks++; if (rnd_valid4 !== 1'b0 || busy4 !== 1'b0) begin failures++; $display("[TB] FAIL hs_req_ack got=%0b/%0b exp=0/0", rnd_valid4, busy4); end
    tick();
    checks++; if (busy4 !== 1'b0) begin failures++; $display("[TB] FAIL hs_no_step got=%0b exp=0", busy4); end
    ack4 = 1'b1;
    tick();
    ack4 = 1'b0;
    checks++; if (rnd_valid4 !== 1'b0 || busy4 !== 1'b0) begin failures++; $display("[TB] FAIL hs_idle_ack got=%0b/%0b exp=0/0", rnd_valid4, busy4); end
    req4 = 1'b1;
    tick();
    req4 = 1'b0;
    checks++; if (busy4 !== 1'b1) begin failures++; $display("[TB] FAIL hs_reaccept got=%0b exp=1", busy4); end
    repeat (4) tick();
    ack4 = 1'b1;
    tick();
    ack4 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int first_hit;
    int hits;
    first_hit = -1;
    hits = 0;
    req4 = 1'b1; ack4 = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (rnd_valid4 === 1'b1) begin
        hits++;
        if (first_hit < 0) first_hit = i;
      end
    end
    req4 = 1'b0; ack4 = 1'b0;
    checks++; if (first_hit !== 5) begin failures++; $display("[TB] FAIL b2b_latency got=%0d exp=5", first_hit); end
    checks++; if (hits !== 4) begin failures++; $display("[TB] FAIL b2b_samples got=%0d exp=4", hits); end
    repeat (8) tick();
    ack4 = 1'b1;
    tick();
    ack4 = 1'b0;
  endtask

`ifdef RNG_STIR_EN
  task automatic test_stir();
    seed_load4 = 1'b1; seed4 = 32'h1;
    tick();
    seed_load4 = 1'b0;
    stir4 = 1'b1; stir_data4 = 32'h80200003;
    tick();
    stir4 = 1'b0; stir_data4 = 32'h0;
    checks++; if (dut4.lfsr_q !== 32'h00000001) begin failures++; $display("[TB] FAIL stir_zero got=%h exp=00000001", dut4.lfsr_q); end
    stir4 = 1'b1; stir_data4 = 32'h0000000F;
    tick();
    stir4 = 1'b0; stir_data4 = 32'h0;
    checks++; if (dut4.lfsr_q !== 32'h8020000C) begin failures++; $display("[TB] FAIL stir_mix got=%h exp=8020000C", dut4.lfsr_q); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    seed_load4 = 1'b0; seed4 = '0; req4 = 1'b0; ack4 = 1'b0;
    seed_load1 = 1'b0; seed1 = '0; req1 = 1'b0; ack1 = 1'b0;
`ifdef RNG_STIR_EN
    stir4 = 1'b0; stir_data4 = '0; stir1 = 1'b0; stir_data1 = '0;
`endif
    #1;
    test_reset();
    test_steps1();
    test_zero_seed();
    test_steps4();
    test_handshake();
    test_back_to_back();
`ifdef RNG_STIR_EN
    test_stir();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
